// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer
//  Description : Microinstruction fetch/decode/execute sequencer. Fetches a
//                uROM word at m_pc, holds the decoded IR fields that steer
//                write_bus, then commits write_bus_in into the addressed
//                destination register or into m_pc.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter int MPC_WIDTH   = 8,
  parameter int MINST_WIDTH = 21,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic                   stall,
  output logic                   urom_rd,
  output logic [MPC_WIDTH-1:0]   urom_addr,
  input  logic [MINST_WIDTH-1:0] urom_data,
  input  logic [DATA_WIDTH-1:0]  write_bus_in,
  output logic [2:0]             minstr_type,
  output logic [ADDR_WIDTH-1:0]  reg_src,
  output logic [ADDR_WIDTH-1:0]  reg_dst,
  output logic [DATA_WIDTH-1:0]  imm,
  output logic [DATA_WIDTH-1:0]  mbranch_target,
  output logic [MPC_WIDTH-1:0]   m_pc,
  output logic [DATA_WIDTH-1:0]  a_reg,
  output logic [DATA_WIDTH-1:0]  b_reg,
  output logic [DATA_WIDTH-1:0]  reg_sel,
  output logic [DATA_WIDTH-1:0]  reg_wr_data,
  output logic                   exec_valid,
  output logic                   halted
);

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Microinstruction types with sequencer-visible behaviour
  localparam logic [2:0] T_BRANCH = 3'b011;
  localparam logic [2:0] T_JUMP   = 3'b100;
  localparam logic [2:0] T_HALT   = 3'b101;

  // Destination register map
  localparam logic [ADDR_WIDTH-1:0] A_REG_MAP       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] B_REG_MAP       = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] REG_SEL_MAP     = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] REG_WR_DATA_MAP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] M_PC_MAP        = ADDR_WIDTH'(5);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       commit;

  // Commit happens on the edge that leaves EXEC; a stall simply defers it.
  assign commit         = (state == ST_EXEC) && !stall;
  assign urom_addr      = m_pc;
  // Branch target and immediate share the same IR bits.
  assign mbranch_target = imm;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; start is only honoured while parked in IDLE or HALT
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   if (!stall) state_nxt = (minstr_type == T_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   if (start) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    urom_rd    = (state == ST_FETCH);
    exec_valid = commit;
    halted     = (state == ST_IDLE) || (state == ST_HALT);
  end

  // IR load in DECODE, m_pc advance, and single-destination commit in EXEC
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      minstr_type <= '0;
      reg_src     <= '0;
      reg_dst     <= '0;
      imm         <= '0;
      m_pc        <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      reg_sel     <= '0;
      reg_wr_data <= '0;
    end else begin
      if (state == ST_DECODE) begin
        minstr_type <= urom_data[2:0];
        reg_src     <= urom_data[3 +: ADDR_WIDTH];
        reg_dst     <= urom_data[8 +: ADDR_WIDTH];
        imm         <= urom_data[MINST_WIDTH-1 -: DATA_WIDTH];
        m_pc        <= m_pc + 1'b1;
      end
      if (commit) begin
        // write_bus already resolved taken/not-taken, so both reload from the bus
        if ((minstr_type == T_BRANCH) || (minstr_type == T_JUMP)) begin
          m_pc <= write_bus_in[MPC_WIDTH-1:0];
        end else if (minstr_type != T_HALT) begin
          case (reg_dst)
            A_REG_MAP:       a_reg       <= write_bus_in;
            B_REG_MAP:       b_reg       <= write_bus_in;
            REG_SEL_MAP:     reg_sel     <= write_bus_in;
            REG_WR_DATA_MAP: reg_wr_data <= write_bus_in;
            M_PC_MAP:        m_pc        <= write_bus_in[MPC_WIDTH-1:0];
            default:         ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_sequencer
//  Description : Self-checking bench for micro_sequencer: directed vector
//                table, reset-in-DECODE sequence, and randomized programs
//                checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  localparam logic [4:0] A_MAP  = 5'd1;
  localparam logic [4:0] B_MAP  = 5'd2;
  localparam logic [4:0] S_MAP  = 5'd3;
  localparam logic [4:0] W_MAP  = 5'd4;
  localparam logic [4:0] PC_MAP = 5'd5;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic        stall   = 1'b0;
  logic        urom_rd;
  logic [7:0]  urom_addr;
  logic [20:0] urom_data = '0;
  logic [7:0]  write_bus_in;
  logic [2:0]  minstr_type;
  logic [4:0]  reg_src, reg_dst;
  logic [7:0]  imm, mbranch_target, m_pc;
  logic [7:0]  a_reg, b_reg, reg_sel, reg_wr_data;
  logic        exec_valid, halted;

  logic [20:0] urom [256];
  logic        bus_taken = 1'b0;
  logic [7:0]  bus_other = '0;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_a, m_b, m_s, m_w, m_pcr;

  micro_sequencer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stall(stall),
    .urom_rd(urom_rd), .urom_addr(urom_addr), .urom_data(urom_data),
    .write_bus_in(write_bus_in), .minstr_type(minstr_type),
    .reg_src(reg_src), .reg_dst(reg_dst), .imm(imm),
    .mbranch_target(mbranch_target), .m_pc(m_pc), .a_reg(a_reg),
    .b_reg(b_reg), .reg_sel(reg_sel), .reg_wr_data(reg_wr_data),
    .exec_valid(exec_valid), .halted(halted)
  );

  always #5 sys_clk = ~sys_clk;

  // uROM: registered read, data valid the cycle after urom_rd
  always @(posedge sys_clk) if (urom_rd) urom_data <= urom[urom_addr];

  // write_bus environment: MOVE carries imm, branch picks target or fall-through
  assign write_bus_in = (minstr_type == 3'b000) ? imm :
                        (minstr_type == 3'b011) ? (bus_taken ? mbranch_target : m_pc) :
                        (minstr_type == 3'b100) ? mbranch_target : bus_other;

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic [2:0] t, input logic [4:0] s,
                                     input logic [4:0] d, input logic [7:0] i);
    return {i, d, s, t};
  endfunction

  task automatic check_regs();
    chk("a_reg", a_reg, m_a);
    chk("b_reg", b_reg, m_b);
    chk("reg_sel", reg_sel, m_s);
    chk("reg_wr_data", reg_wr_data, m_w);
    chk("m_pc", m_pc, m_pcr);
  endtask

  task automatic check_reset();
    chk("rst_m_pc", m_pc, 0);
    chk("rst_urom_addr", urom_addr, 0);
    chk("rst_a", a_reg, 0);
    chk("rst_b", b_reg, 0);
    chk("rst_sel", reg_sel, 0);
    chk("rst_wd", reg_wr_data, 0);
    chk("rst_type", minstr_type, 0);
    chk("rst_src", reg_src, 0);
    chk("rst_dst", reg_dst, 0);
    chk("rst_imm", imm, 0);
    chk("rst_tgt", mbranch_target, 0);
    chk("rst_urom_rd", urom_rd, 0);
    chk("rst_exec_valid", exec_valid, 0);
    chk("rst_halted", halted, 1);
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_s = 0; m_w = 0; m_pcr = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // Runs one microinstruction starting from FETCH; ends in FETCH (or after a
  // HALT, after resuming with start) with the model updated.
  task automatic do_uop(input logic [20:0] word, input logic tk, input logic [7:0] oth,
                        input int stalls, input logic noise);
    logic [2:0] typ;
    logic [4:0] dst;
    logic [7:0] im, bus;
    typ = word[2:0]; dst = word[12:8]; im = word[20:13];
    urom[m_pcr] = word;
    bus_taken = tk;
    bus_other = oth;
    chk("fetch_rd", urom_rd, 1);
    chk("fetch_addr", urom_addr, m_pcr);
    chk("fetch_halted", halted, 0);
    start = noise & ($urandom_range(0, 1) == 1);
    @(posedge sys_clk); #1;
    chk("decode_rd", urom_rd, 0);
    chk("decode_ev", exec_valid, 0);
    @(posedge sys_clk); #1;
    start = 1'b0;
    m_pcr = m_pcr + 8'd1;
    chk("ir_type", minstr_type, typ);
    chk("ir_src", reg_src, word[7:3]);
    chk("ir_dst", reg_dst, dst);
    chk("ir_imm", imm, im);
    chk("ir_tgt", mbranch_target, im);
    chk("exec_pc", m_pc, m_pcr);
    stall = (stalls > 0);
    #1;
    for (int i = 0; i < stalls; i++) begin
      chk("stall_ev", exec_valid, 0);
      @(posedge sys_clk); #1;
      check_regs();
      chk("stall_halted", halted, 0);
    end
    stall = 1'b0;
    #1;
    if (typ != 3'b101) chk("commit_ev", exec_valid, 1);
    // model: bus value as write_bus would present it, then the commit rules
    case (typ)
      3'b000:  bus = im;
      3'b011:  bus = tk ? im : m_pcr;
      3'b100:  bus = im;
      default: bus = oth;
    endcase
    if (typ == 3'b011 || typ == 3'b100) m_pcr = bus;
    else if (typ != 3'b101) begin
      if (dst == A_MAP)       m_a = bus;
      else if (dst == B_MAP)  m_b = bus;
      else if (dst == S_MAP)  m_s = bus;
      else if (dst == W_MAP)  m_w = bus;
      else if (dst == PC_MAP) m_pcr = bus;
    end
    @(posedge sys_clk); #1;
    check_regs();
    chk("post_ev", exec_valid, 0);
    if (typ == 3'b101) begin
      chk("halt_halted", halted, 1);
      chk("halt_rd", urom_rd, 0);
      repeat (2) begin @(posedge sys_clk); #1; end
      check_regs();
      chk("halt_hold", halted, 1);
      pulse_start();
    end else begin
      chk("run_halted", halted, 0);
    end
  endtask

  typedef struct {
    logic [20:0] word;
    logic        taken;
    logic [7:0]  other;
    int          stalls;
    logic [7:0]  ea, eb, es, ew, epc;
  } vec_t;

  vec_t vt [16];

  initial begin
    logic [31:0] r;
    logic [4:0]  d;
    logic [2:0]  t;

    for (int i = 0; i < 256; i++) urom[i] = '0;

    // directed program from reset; expectations computed by hand
    vt[0]  = '{mk(3'b000, 5'd0, A_MAP,  8'h5A), 1'b0, 8'h00, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h01};
    vt[1]  = '{mk(3'b000, 5'd2, B_MAP,  8'h3C), 1'b0, 8'h00, 4, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h02};
    vt[2]  = '{mk(3'b010, 5'd1, S_MAP,  8'h00), 1'b0, 8'h77, 0, 8'h5A, 8'h3C, 8'h77, 8'h00, 8'h03};
    vt[3]  = '{mk(3'b000, 5'd0, W_MAP,  8'h99), 1'b0, 8'h00, 1, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h04};
    vt[4]  = '{mk(3'b000, 5'd0, PC_MAP, 8'h07), 1'b0, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h07};
    vt[5]  = '{mk(3'b011, 5'd0, 5'd0,   8'h20), 1'b1, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h20};
    vt[6]  = '{mk(3'b000, 5'd0, PC_MAP, 8'h07), 1'b0, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h07};
    vt[7]  = '{mk(3'b011, 5'd0, 5'd0,   8'h20), 1'b0, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h08};
    vt[8]  = '{mk(3'b100, 5'd0, A_MAP,  8'hFF), 1'b0, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'hFF};
    vt[9]  = '{mk(3'b100, 5'd0, 5'd0,   8'h30), 1'b0, 8'h00, 2, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h30};
    vt[10] = '{mk(3'b000, 5'd0, PC_MAP, 8'hFF), 1'b0, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'hFF};
    vt[11] = '{mk(3'b000, 5'd0, 5'h1F,  8'h12), 1'b0, 8'h00, 0, 8'h5A, 8'h3C, 8'h77, 8'h99, 8'h00};
    vt[12] = '{mk(3'b010, 5'd0, A_MAP,  8'h00), 1'b0, 8'hC3, 0, 8'hC3, 8'h3C, 8'h77, 8'h99, 8'h01};
    vt[13] = '{mk(3'b000, 5'd0, PC_MAP, 8'h03), 1'b0, 8'h00, 0, 8'hC3, 8'h3C, 8'h77, 8'h99, 8'h03};
    vt[14] = '{mk(3'b101, 5'd0, A_MAP,  8'hEE), 1'b0, 8'h00, 0, 8'hC3, 8'h3C, 8'h77, 8'h99, 8'h04};
    vt[15] = '{mk(3'b001, 5'd0, B_MAP,  8'h00), 1'b0, 8'h44, 0, 8'hC3, 8'h44, 8'h77, 8'h99, 8'h05};

    // reset and idle
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    model_reset();
    check_reset();
    repeat (2) begin @(posedge sys_clk); #1; end
    chk("idle_halted", halted, 1);
    chk("idle_rd", urom_rd, 0);
    pulse_start();

    for (int i = 0; i < 16; i++) begin
      do_uop(vt[i].word, vt[i].taken, vt[i].other, vt[i].stalls, 1'b0);
      chk("vec_a", a_reg, vt[i].ea);
      chk("vec_b", b_reg, vt[i].eb);
      chk("vec_sel", reg_sel, vt[i].es);
      chk("vec_wd", reg_wr_data, vt[i].ew);
      chk("vec_pc", m_pc, vt[i].epc);
    end

    // asynchronous reset while in DECODE discards the instruction
    urom[m_pcr] = mk(3'b000, 5'd0, A_MAP, 8'hAB);
    @(posedge sys_clk); #1;
    chk("pre_rst_rd", urom_rd, 0);
    sys_rst = 1'b1;
    #1;
    check_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    model_reset();
    repeat (3) begin @(posedge sys_clk); #1; end
    check_reset();
    pulse_start();

    // randomized programs against the behavioural model
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      t = r[2:0];
      d = (r[5:3] < 3'd5) ? (5'd1 + {2'b00, r[5:3]}) : r[12:8];
      r = $urandom;
      do_uop(mk(t, r[4:0], d, r[12:5]), r[13], r[21:14], int'(r[23:22] % 2'd3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
